// File: rtl/mole_field_renderer.sv
// mole_field_renderer: draws a ROWS x COLS grid of elliptical holes and runs
// one mole animation FSM per hole (IDLE -> RISING -> UP -> FALLING -> IDLE),
// advanced once per frame_tick. Pixel colour is registered (1-cycle latency).
//
// Optional feature macro: HIT_FLASH_EN
//   defined   : an accepted hit holds the mole red (FLASH) for FLASH_FRAMES
//               ticks before it falls.
//   undefined : an accepted hit goes straight to FALLING; no FLASH state.
//
// Handshake: pop_req/hit_req are level requests sampled every cycle with no
// ready/backpressure; a pop is taken only in IDLE, a hit only in RISING/UP,
// and each accepted hit produces exactly one hit_ack pulse the following
// cycle. Requests arriving in any other state are dropped, never queued.
//
// Debug: state_dbg packs each hole's 3-bit FSM state (IDLE encodes as 0, so
// an all-zero state_dbg means every hole is idle); height_dbg packs each
// hole's current mole height h. RISE_STEP must not exceed MOLE_H.
module mole_field_renderer #(
  parameter int ROWS         = 2,
  parameter int COLS         = 3,
  parameter int ORIGIN_X     = 120,
  parameter int ORIGIN_Y     = 160,
  parameter int PITCH_X      = 200,
  parameter int PITCH_Y      = 180,
  parameter int HOLE_RX      = 60,
  parameter int HOLE_RY      = 24,
  parameter int MOLE_W       = 60,
  parameter int MOLE_H       = 80,
  parameter int RISE_STEP    = 4,
  parameter int UP_FRAMES    = 60,
`ifdef HIT_FLASH_EN
  parameter int FLASH_FRAMES = 8,
  localparam int TMAX        = (UP_FRAMES > FLASH_FRAMES) ? UP_FRAMES : FLASH_FRAMES,
`else
  localparam int TMAX        = UP_FRAMES,
`endif
  localparam int N           = ROWS * COLS,
  localparam int HW          = $clog2(MOLE_H + 1),
  localparam int TW          = $clog2(TMAX + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frame_tick,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic            video_on,
  input  logic [N-1:0]    pop_req,
  input  logic [N-1:0]    hit_req,
  output logic [3:0]      red,
  output logic [3:0]      green,
  output logic [3:0]      blue,
  output logic [N-1:0]    mole_up,
  output logic [N-1:0]    hit_ack,
  output logic            busy,
  output logic [3*N-1:0]  state_dbg,
  output logic [HW*N-1:0] height_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISING  = 3'd1,
    S_UP      = 3'd2,
    S_FALLING = 3'd3
`ifdef HIT_FLASH_EN
    ,
    S_FLASH   = 3'd4
`endif
  } hole_state_e;

  // Height constants: a rising mole saturates once h reaches H_RISE_LIM,
  // a falling mole lands once h is at or below H_STEP.
  localparam logic [HW-1:0] H_MAX      = HW'(MOLE_H);
  localparam logic [HW-1:0] H_STEP     = HW'(RISE_STEP);
  localparam logic [HW-1:0] H_RISE_LIM = HW'(MOLE_H - RISE_STEP);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] T_UP       = TW'(UP_FRAMES);
`ifdef HIT_FLASH_EN
  localparam logic [TW-1:0] T_FLASH    = TW'(FLASH_FRAMES);
`endif

  // Ellipse constants, all 32-bit unsigned as the products are.
  localparam logic [31:0] RX2    = 32'(HOLE_RX * HOLE_RX);
  localparam logic [31:0] RY2    = 32'(HOLE_RY * HOLE_RY);
  localparam logic [31:0] RX2RY2 = 32'(HOLE_RX * HOLE_RX * HOLE_RY * HOLE_RY);
  localparam logic [9:0]  HALF_W = 10'(MOLE_W / 2);

  logic [N-1:0] mole_vec;
  logic [N-1:0] hole_vec;
  logic [N-1:0] flash_vec;
  logic [N-1:0] busy_vec;
  logic [11:0]  rgb_d;

  for (genvar i = 0; i < N; i++) begin : g_hole
    localparam int CX = ORIGIN_X + (i % COLS) * PITCH_X;
    localparam int CY = ORIGIN_Y + (i / COLS) * PITCH_Y;

    hole_state_e   state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [TW-1:0] t_q, t_d;
    logic          ack_q, ack_d;
    logic [9:0]    dx, dy;
    logic [31:0]   dx32, dy32, ell_lhs;

    // Next-state logic: an accepted hit overrides any frame step that cycle.
    always_comb begin
      state_d = state_q;
      h_d     = h_q;
      t_d     = t_q;
      ack_d   = 1'b0;
      if (hit_req[i] && (state_q == S_RISING || state_q == S_UP)) begin
        ack_d = 1'b1;
`ifdef HIT_FLASH_EN
        state_d = S_FLASH;
        t_d     = T_FLASH;
`else
        state_d = S_FALLING;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (pop_req[i]) begin
              state_d = S_RISING;
              h_d     = '0;
              t_d     = '0;
            end
          end
          S_RISING: begin
            if (frame_tick) begin
              if (h_q >= H_RISE_LIM) begin
                h_d     = H_MAX;
                state_d = S_UP;
                t_d     = T_UP;
              end else begin
                h_d = h_q + H_STEP;
              end
            end
          end
          S_UP: begin
            if (frame_tick) begin
              if (t_q <= T_ONE) begin
                t_d     = '0;
                state_d = S_FALLING;
              end else begin
                t_d = t_q - T_ONE;
              end
            end
          end
          S_FALLING: begin
            if (frame_tick) begin
              if (h_q <= H_STEP) begin
                h_d     = '0;
                state_d = S_IDLE;
              end else begin
                h_d = h_q - H_STEP;
              end
            end
          end
`ifdef HIT_FLASH_EN
          S_FLASH: begin
            if (frame_tick) begin
              if (t_q <= T_ONE) begin
                t_d     = '0;
                state_d = S_FALLING;
              end else begin
                t_d = t_q - T_ONE;
              end
            end
          end
`endif
          default: begin
            state_d = S_IDLE;
            h_d     = '0;
            t_d     = '0;
          end
        endcase
      end
    end

    // Per-hole state, height, timer and ack registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
        h_q     <= '0;
        t_q     <= '0;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        h_q     <= h_d;
        t_q     <= t_d;
        ack_q   <= ack_d;
      end
    end

    // Pixel geometry for this hole: distances from the hole centre.
    assign dx      = (x >= 10'(CX)) ? (x - 10'(CX)) : (10'(CX) - x);
    assign dy      = (y >= 10'(CY)) ? (y - 10'(CY)) : (10'(CY) - y);
    assign dx32    = 32'(dx);
    assign dy32    = 32'(dy);
    assign ell_lhs = dx32 * dx32 * RY2 + dy32 * dy32 * RX2;

    assign hole_vec[i] = (ell_lhs <= RX2RY2);
    assign mole_vec[i] = (dx < HALF_W) &&
                         (({1'b0, y} + 11'(h_q)) >= 11'(CY)) &&
                         (y < 10'(CY));
`ifdef HIT_FLASH_EN
    assign flash_vec[i] = mole_vec[i] && (state_q == S_FLASH);
`else
    assign flash_vec[i] = 1'b0;
`endif

    assign busy_vec[i]              = (state_q != S_IDLE);
    assign mole_up[i]               = (state_q == S_UP);
    assign hit_ack[i]               = ack_q;
    assign state_dbg[3*i +: 3]      = state_q;
    assign height_dbg[HW*i +: HW]   = h_q;
  end

  assign busy = |busy_vec;

  // Colour priority: blanking, then mole (red while flashing), hole, grass.
  always_comb begin
    rgb_d = 12'h080;
    if (!video_on) begin
      rgb_d = 12'h000;
    end else if (|flash_vec) begin
      rgb_d = 12'hF00;
    end else if (|mole_vec) begin
      rgb_d = 12'h841;
    end else if (|hole_vec) begin
      rgb_d = 12'h111;
    end
  end

  // Registered pixel output, blanked immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else begin
      red   <= rgb_d[11:8];
      green <= rgb_d[7:4];
      blue  <= rgb_d[3:0];
    end
  end

endmodule
